// File: rtl/bus_round_robin_arbiter_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
package bus_round_robin_arbiter_pkg;

  typedef logic [1:0] bus_arb_state_t;
  typedef logic [1:0] bus_owner_t;
  typedef logic [7:0] bus_arb_count_t;

  localparam bus_arb_state_t BUS_ARB_IDLE     = 2'd0;
  localparam bus_arb_state_t BUS_ARB_OWN      = 2'd1;
  localparam bus_arb_state_t BUS_ARB_HANDOVER = 2'd2;

  // Active-low one-cold grant vector for a given owner index.
  function automatic logic [3:0] grant_vec(input bus_owner_t owner);
    return ~(4'b0001 << owner);
  endfunction

endpackage

// File: rtl/bus_round_robin_arbiter_if.sv
// Shared-bus request/grant and transaction-boundary signals, all active-low.
interface bus_round_robin_arbiter_if;
  logic master0_request_;
  logic master1_request_;
  logic master2_request_;
  logic master3_request_;
  logic master0_grant_;
  logic master1_grant_;
  logic master2_grant_;
  logic master3_grant_;
  logic bus_address_strobe_;
  logic bus_ready_;

  modport master (
    output master0_request_, master1_request_, master2_request_, master3_request_,
    output bus_address_strobe_, bus_ready_,
    input  master0_grant_, master1_grant_, master2_grant_, master3_grant_
  );

  modport slave (
    input  master0_request_, master1_request_, master2_request_, master3_request_,
    input  bus_address_strobe_, bus_ready_,
    output master0_grant_, master1_grant_, master2_grant_, master3_grant_
  );
endinterface

// File: rtl/bus_round_robin_picker.sv
// Combinational round-robin winner search starting just after the last owner.
module bus_round_robin_picker
  import bus_round_robin_arbiter_pkg::*;
(
  input  logic [3:0] request_n,
  input  bus_owner_t last_owner,
  output bus_owner_t winner,
  output logic       valid
);

  bus_owner_t idx;

  // Scan last_owner+1 .. last_owner+4 so the previous owner is considered last.
  always_comb begin
    winner = last_owner;
    valid  = 1'b0;
    idx    = last_owner;
    for (int i = 1; i <= 4; i++) begin
      idx = last_owner + 2'(i);
      if (!valid && !request_n[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin bus arbiter with per-owner hold limit and stalled-slave watchdog.
module bus_round_robin_arbiter
  import bus_round_robin_arbiter_pkg::*;
#(
  parameter int HOLD_LIMIT = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  bus_round_robin_arbiter_if.slave    bus,
  output bus_owner_t                  bus_owner,
  output logic                        bus_busy,
  output logic                        bus_timeout,
  output bus_owner_t                  timeout_owner
);

  localparam bus_arb_count_t HOLD_MAX    = bus_arb_count_t'(HOLD_LIMIT);
  localparam bus_arb_count_t TIMEOUT_MAX = bus_arb_count_t'(TIMEOUT);

  bus_arb_state_t state;
  bus_arb_count_t hold_count;
  bus_arb_count_t wait_count;
  bus_arb_count_t wait_next;
  logic [3:0]     request_n;
  logic [3:0]     grant_n;
  bus_owner_t     winner;
  logic           winner_valid;
  logic           waiting;
  logic           boundary;
  logic           others_req;
  logic           watchdog_hit;
  logic           voluntary_release;

  assign request_n = {bus.master3_request_, bus.master2_request_,
                      bus.master1_request_, bus.master0_request_};

  assign bus.master0_grant_ = grant_n[0];
  assign bus.master1_grant_ = grant_n[1];
  assign bus.master2_grant_ = grant_n[2];
  assign bus.master3_grant_ = grant_n[3];
  assign bus_busy           = ~&grant_n;

  bus_round_robin_picker u_picker (
    .request_n  (request_n),
    .last_owner (bus_owner),
    .winner     (winner),
    .valid      (winner_valid)
  );

  always_comb begin
    waiting           = !bus.bus_address_strobe_ && bus.bus_ready_;
    boundary          = bus.bus_address_strobe_ || !bus.bus_ready_;
    wait_next         = wait_count + 8'd1;
    watchdog_hit      = waiting && (wait_next == TIMEOUT_MAX);
    others_req        = |(~request_n & ~(4'b0001 << bus_owner));
    voluntary_release = boundary &&
                        (request_n[bus_owner] || ((hold_count == HOLD_MAX) && others_req));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= BUS_ARB_IDLE;
      grant_n       <= 4'b1111;
      bus_owner     <= 2'd3;
      bus_timeout   <= 1'b0;
      timeout_owner <= 2'd0;
      hold_count    <= '0;
      wait_count    <= '0;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        BUS_ARB_IDLE, BUS_ARB_HANDOVER: begin
          if (winner_valid) begin
            grant_n    <= grant_vec(winner);
            bus_owner  <= winner;
            // The grant cycle itself is the first owned cycle.
            hold_count <= 8'd1;
            wait_count <= '0;
            state      <= BUS_ARB_OWN;
          end else begin
            state <= BUS_ARB_IDLE;
          end
        end
        BUS_ARB_OWN: begin
          if (watchdog_hit || voluntary_release) begin
            if (watchdog_hit) begin
              bus_timeout   <= 1'b1;
              timeout_owner <= bus_owner;
            end
            grant_n    <= 4'b1111;
            hold_count <= '0;
            wait_count <= '0;
            state      <= BUS_ARB_HANDOVER;
          end else begin
            if (hold_count != HOLD_MAX) hold_count <= hold_count + 8'd1;
            wait_count <= waiting ? wait_next : 8'd0;
          end
        end
        default: begin
          grant_n <= 4'b1111;
          state   <= BUS_ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Directed vector bench for bus_round_robin_arbiter (HOLD_LIMIT=4, TIMEOUT=8).
module tb_bus_round_robin_arbiter;

  typedef struct {
    logic       rs;
    logic [3:0] req;
    logic       stb;
    logic       rdy;
    logic [3:0] eg;
    logic [1:0] eo;
    logic       eb;
    logic       et;
    logic [1:0] eto;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] bus_owner;
  logic       bus_busy;
  logic       bus_timeout;
  logic [1:0] timeout_owner;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       tbl[$];

  bus_round_robin_arbiter_if bus ();

  bus_round_robin_arbiter #(.HOLD_LIMIT(4), .TIMEOUT(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .bus_owner     (bus_owner),
    .bus_busy      (bus_busy),
    .bus_timeout   (bus_timeout),
    .timeout_owner (timeout_owner)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rs, logic [3:0] req, logic stb, logic rdy,
                              logic [3:0] eg, logic [1:0] eo, logic eb, logic et,
                              logic [1:0] eto);
    vec_t v;
    v.rs = rs; v.req = req; v.stb = stb; v.rdy = rdy;
    v.eg = eg; v.eo = eo; v.eb = eb; v.et = et; v.eto = eto;
    return v;
  endfunction

  task automatic drive(input logic [3:0] req, input logic stb, input logic rdy);
    bus.master0_request_    = req[0];
    bus.master1_request_    = req[1];
    bus.master2_request_    = req[2];
    bus.master3_request_    = req[3];
    bus.bus_address_strobe_ = stb;
    bus.bus_ready_          = rdy;
  endtask

  task automatic cyc(input logic [3:0] req, input logic stb, input logic rdy);
    drive(req, stb, rdy);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] eo,
                     input logic eb, input logic et, input logic [1:0] eto);
    logic [3:0] g;
    g = {bus.master3_grant_, bus.master2_grant_, bus.master1_grant_, bus.master0_grant_};
    n_vec++;
    if (g !== eg || bus_owner !== eo || bus_busy !== eb ||
        bus_timeout !== et || timeout_owner !== eto) begin
      n_bad++;
      $display("FAIL %s: got grant_n=%b owner=%0d busy=%b timeout=%b tout_owner=%0d, want grant_n=%b owner=%0d busy=%b timeout=%b tout_owner=%0d",
               name, g, bus_owner, bus_busy, bus_timeout, timeout_owner,
               eg, eo, eb, et, eto);
    end
  endtask

  task automatic do_reset();
    drive(4'b1111, 1'b1, 1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Rotation with all four masters requesting: 4 owned cycles, 1 dead cycle each.
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 4; k++)
        tbl.push_back(mk(m == 0 && k == 0, 4'b0000, 1'b1, 1'b1,
                         ~(4'b0001 << m), 2'(m), 1'b1, 1'b0, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'(m), 1'b0, 1'b0, 2'd0));
    end
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    // Masters 0 and 2 together, master0 first, then master2 after the dead cycle.
    tbl.push_back(mk(1'b1, 4'b1010, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0, 2'd0));

    drive(4'b1111, 1'b1, 1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 4'b1111, 2'd3, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      cyc(tbl[i].req, tbl[i].stb, tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eo, tbl[i].eb, tbl[i].et, tbl[i].eto);
    end

    // Hold limit reached mid-transaction: switch only after the completing cycle.
    do_reset();
    cyc(4'b1101, 1'b1, 1'b1);
    chk("hold_grant", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1100, 1'b0, 1'b1);
      chk("hold_inflight", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);
    end
    cyc(4'b1100, 1'b0, 1'b0);
    chk("hold_release", 4'b1111, 2'd1, 1'b0, 1'b0, 2'd0);
    cyc(4'b1100, 1'b1, 1'b1);
    chk("hold_next", 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0);

    // Watchdog: ready never arrives for master2.
    do_reset();
    cyc(4'b1011, 1'b1, 1'b1);
    chk("to_grant", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(4'b1011, 1'b0, 1'b1);
      chk("to_wait", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0);
    end
    cyc(4'b1011, 1'b0, 1'b1);
    chk("to_fire", 4'b1111, 2'd2, 1'b0, 1'b1, 2'd2);
    cyc(4'b1011, 1'b0, 1'b1);
    chk("to_regrant", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd2);

    // Hand over to master1, then reset asynchronously mid-transaction.
    cyc(4'b1101, 1'b1, 1'b1);
    chk("rst_release2", 4'b1111, 2'd2, 1'b0, 1'b0, 2'd2);
    cyc(4'b1101, 1'b1, 1'b1);
    chk("rst_grant1", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd2);
    cyc(4'b1101, 1'b0, 1'b1);
    chk("rst_inflight", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", 4'b1111, 2'd3, 1'b0, 1'b0, 2'd0);
    drive(4'b1101, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("after_reset", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);

    // Lone master3 keeps the bus past the hold limit.
    do_reset();
    cyc(4'b0111, 1'b1, 1'b1);
    chk("solo_grant", 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0111, (i % 2) == 0, (i % 2) == 0);
      chk("solo_hold", 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_round_robin_arbiter.md
# bus_round_robin_arbiter

Fair bus arbiter for the four-master shared bus. It replaces fixed-priority arbitration with round-robin selection, a per-master hold limit and a stalled-slave watchdog. It drives the active-low `masterN_grant_` lines that the master multiplexer uses to select the bus owner. It also observes the muxed address strobe and the muxed slave ready to find transaction boundaries.

## Interface
Parameters:
- `HOLD_LIMIT`, 16: cycles an owner may keep the bus before it must yield to a waiting master (1..255).
- `TIMEOUT`, 255: cycles a strobed access may wait for ready before a forced release (1..255).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `master0_request_`..`master3_request_` in 1 each: bus request, active-low.
- `master0_grant_`..`master3_grant_` out 1 each: bus grant, active-low, registered.
- `bus_address_strobe_` in 1: muxed `slave_address_strobe_`, active-low.
- `bus_ready_` in 1: muxed `master_ready_`, active-low.
- `bus_owner` out 2: index of the current or last owner.
- `bus_busy` out 1: high while any grant is asserted.
- `bus_timeout` out 1: one-cycle pulse on a watchdog expiry.
- `timeout_owner` out 2: owner index latched at the last timeout.

## Operation
- States are IDLE, OWN and HANDOVER.
- **Reset:**
  - All grants 1; `bus_owner`=3, so master0 wins first.
  - `bus_busy`=0, `bus_timeout`=0, `timeout_owner`=0.
  - Counters cleared; state IDLE.
- **Winner selection:** the first requesting index found scanning `bus_owner+1`, `+2`, `+3`, `+0` (mod 4).
- **IDLE:**
  - Any request low → pick the winner, register its grant, load `bus_owner`, go to OWN.
  - No request → stay in IDLE.
- **OWN:**
  - `hold_count` increments each cycle and saturates at `HOLD_LIMIT`.
  - A transaction is in flight while `bus_address_strobe_`=0. It completes in a cycle where strobe=0 and `bus_ready_`=0.
  - A boundary is a cycle with strobe=1, or a completing cycle.
  - Release A: the owner's request is 1 at a boundary.
  - Release B: `hold_count`==`HOLD_LIMIT`, another master is requesting, and the cycle is a boundary.
  - Release C (watchdog): `wait_count` reaches `TIMEOUT`. Pulse `bus_timeout`, latch `timeout_owner`=`bus_owner` and release regardless of the request or strobe.
  - On release: drop all grants, clear the counters, go to HANDOVER.
- **Watchdog counter:**
  - `wait_count` increments when strobe=0 and `bus_ready_`=1.
  - It clears when strobe=1 or `bus_ready_`=0.
- **HANDOVER:**
  - One dead cycle with all grants 1.
  - Then re-arbitrate exactly as in IDLE. The previous owner has lowest priority.
  - If no request is pending, go to IDLE.
- **Simultaneous events:**
  - Timeout and a voluntary release in the same cycle → timeout takes precedence and the pulse is issued.
  - Requests changing during HANDOVER are sampled in the arbitration cycle only.
- At most one grant is ever 0.

## Timing
- Request sampled low at edge n with the bus idle → grant 0 after edge n+1.
- Release condition true in cycle n:
  - Grant goes to 1 after edge n+1.
  - Next grant goes to 0 after edge n+2.
  - Owner-to-owner latency is 2 cycles.
- `bus_timeout` is high for exactly the one cycle after the edge at which `wait_count` hits `TIMEOUT`.
- `timeout_owner` updates on that same edge and holds until the next timeout.
- Reset low at any time, including mid-transaction → all grants 1 immediately (asynchronous), with all reset values above.

## Structure
- Add to `bus.h`:
  - State encodings `BUS_ARB_IDLE`, `BUS_ARB_OWN`, `BUS_ARB_HANDOVER`, on a 2-bit `BusArbStateBus`.
  - `BusOwnerBus` [1:0].
  - Counter width `BusArbCountBus` [7:0].
- One combinational sub-module: `bus_round_robin_picker`.
  - Inputs: 4-bit active-low request vector and the last owner.
  - Outputs: winner index and a valid flag.
- All registers live in the top module.

## Test plan
- After reset, masters 0 and 2 request together → master0 granted 1 cycle later.
  - Master0 drops its request with strobe=1 → its grant goes to 1.
  - Master2 is granted 2 cycles after the release.
- All four request continuously with `HOLD_LIMIT`=4 and strobe idle → grants rotate 0,1,2,3,0, each held 4 cycles with a 1-cycle dead gap.
- Hold limit expires while strobe=0 and ready=1 → no switch until ready=0. The switch follows that completion.
- Owner strobes and ready never arrives, with `TIMEOUT`=8 → `bus_timeout` pulses once after 8 wait cycles.
  - `timeout_owner` equals the owner.
  - The grant is removed even though the request is still 0.
- Reset asserted mid-transaction with master1 granted → all grants 1 immediately, `bus_owner`=3.
  - After release, a master1-only request is granted 1 cycle later.
- Single requester master3 holds the bus beyond `HOLD_LIMIT` with no contenders → grant never drops and `bus_timeout` stays 0.
